ifu_fetch: RTL and testbench

- Instruction fetch unit: the initiator (master) side of the ifetch request/response protocol.
- Issues sequential PC fetch requests to the bus interface unit, buffers returned instruction words in a small in-order queue, and presents (pc, ir) pairs to the decoder over a valid/ready handshake.
- Handles control-flow redirects from execute by flushing the queue and discarding responses still in flight.

---
 rtl/ifu_fetch_pkg.sv | 18 +
 rtl/ifu_fetch_chk.sv | 27 ++
 rtl/ifu_fetch_sync_fifo.sv | 83 ++++++++
 rtl/ifu_fetch.sv | 156 +++++++++++++++
 tb/tb_ifu_fetch.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_fetch_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fetch_pkg
// Shared core definitions for the instruction fetch path.
//   PC_STEP       : byte distance between consecutive instruction words
//   RST_PC_DEF    : default fetch PC after reset
//   fetch_entry_t : {pc, ir} pair handed from fetch to the decoder stage
// ---------------------------------------------------------------------------
package ifu_fetch_pkg;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] RST_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_chk.sv
// ---------------------------------------------------------------------------
// ifu_fetch_chk
// Protocol checker for the fetch credit counters.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rsp_vld_i   : response valid from the bus interface
//   os_cnt_i    : outstanding request count
//   drop_cnt_i  : count of outstanding responses to be discarded
// ---------------------------------------------------------------------------
module ifu_fetch_chk #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          rsp_vld_i,
    input logic [CW-1:0] os_cnt_i,
    input logic [CW-1:0] drop_cnt_i
);

    // A response always belongs to a request that is still outstanding.
    a_rsp_has_os: assert property (@(posedge clk) disable iff (!rst_n)
        rsp_vld_i |-> (os_cnt_i != {CW{1'b0}}));

    // Only outstanding requests can be marked for discard.
    a_drop_le_os: assert property (@(posedge clk) disable iff (!rst_n)
        drop_cnt_i <= os_cnt_i);

endmodule

// File: rtl/ifu_fetch_sync_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fetch_sync_fifo
// Single-clock FIFO, DEPTH (power of 2, >= 2) entries of W bits.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush_i     : empties the FIFO; overrides any same-cycle push or pop
//   wr_en_i     : push wr_data_i (caller guarantees a free slot or a same-cycle pop)
//   rd_en_i     : pop the head (caller guarantees non-empty)
//   rd_data_o   : head entry
//   count_o     : current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ifu_fetch_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       wr_en_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic                       rd_en_i,
    output logic [W-1:0]               rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Pointer/occupancy next state; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            cnt_d    = CNT_ZERO;
        end else begin
            if (wr_en_i) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en_i) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            cnt_d = cnt_q + (wr_en_i ? CNT_ONE : CNT_ZERO) - (rd_en_i ? CNT_ONE : CNT_ZERO);
        end
    end

    // Storage array, pointers and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            cnt_q    <= CNT_ZERO;
        end else begin
            if (wr_en_i && !flush_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = cnt_q;

endmodule

// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch unit, initiator side of the ifetch request/response bus.
// Issues sequential word-aligned fetches, queues returned words in order and
// hands (pc, ir) pairs to the decoder. A redirect flushes the queue and marks
// every in-flight response for discard.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   req_vld_o/req_rdy_i/req_pc_o : fetch request channel
//   rsp_vld_i/rsp_ir_i           : in-order response channel
//   redirect_vld_i/redirect_pc_i : control-flow redirect (pc[1:0] ignored)
//   inst_vld_o/inst_rdy_i        : decoder handshake
//   inst_ir_o/inst_pc_o          : delivered instruction word and its PC
// ---------------------------------------------------------------------------
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RST_PC   = RST_PC_DEF,
    parameter int            FQ_DEPTH = 2,
    parameter int            MAX_OS   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          req_vld_o,
    input  logic          req_rdy_i,
    output logic [AW-1:0] req_pc_o,
    input  logic          rsp_vld_i,
    input  logic [DW-1:0] rsp_ir_i,
    input  logic          redirect_vld_i,
    input  logic [AW-1:0] redirect_pc_i,
    output logic          inst_vld_o,
    input  logic          inst_rdy_i,
    output logic [DW-1:0] inst_ir_o,
    output logic [AW-1:0] inst_pc_o
);

    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [AW-1:0] STEP     = AW'(PC_STEP);
    localparam logic [AW-1:0] ALIGN    = ~AW'(32'd3);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] MAX_OS_W = CW'(MAX_OS);
    localparam logic [CW:0]   FQ_W     = (CW + 1)'(FQ_DEPTH);

    logic          run_q;
    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] deq_pc_q, deq_pc_d;
    logic [CW-1:0] os_cnt_q, os_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [CW-1:0] q_cnt_s;
    logic [DW-1:0] q_head_s;
    logic [CW:0]   credit_s;
    logic          req_vld_s;
    logic          req_hs_s;
    logic          inst_vld_s;
    logic          deq_hs_s;
    logic          drop_now_s;
    logic          q_wr_s;
    logic          q_rd_s;

    // Issue gate from registers only: live requests plus queued words must fit the queue.
    always_comb begin
        credit_s  = {1'b0, os_cnt_q} - {1'b0, drop_cnt_q} + {1'b0, q_cnt_s};
        req_vld_s = run_q && (os_cnt_q < MAX_OS_W) && (credit_s < FQ_W);
    end

    // Handshakes and queue controls; a redirect discards any arriving word.
    always_comb begin
        req_hs_s   = req_vld_s && req_rdy_i;
        inst_vld_s = (q_cnt_s != CNT_ZERO);
        deq_hs_s   = inst_vld_s && inst_rdy_i;
        drop_now_s = rsp_vld_i && (drop_cnt_q != CNT_ZERO);
        q_wr_s     = rsp_vld_i && !drop_now_s && !redirect_vld_i;
        q_rd_s     = deq_hs_s && !redirect_vld_i;
    end

    // PC and credit next state; redirect overrides every other update.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        deq_pc_d   = deq_pc_q;
        drop_cnt_d = drop_cnt_q;
        os_cnt_d   = os_cnt_q + (req_hs_s ? CNT_ONE : CNT_ZERO) - (rsp_vld_i ? CNT_ONE : CNT_ZERO);
        if (redirect_vld_i) begin
            fetch_pc_d = redirect_pc_i & ALIGN;
            deq_pc_d   = redirect_pc_i & ALIGN;
            // Everything still in flight after this edge belongs to the old path.
            drop_cnt_d = os_cnt_d;
        end else begin
            if (req_hs_s) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (deq_hs_s) begin
                deq_pc_d = deq_pc_q + STEP;
            end else begin
                deq_pc_d = deq_pc_q;
            end
            if (drop_now_s) begin
                drop_cnt_d = drop_cnt_q - CNT_ONE;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // State registers; run rises on the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RST_PC;
            deq_pc_q   <= RST_PC;
            os_cnt_q   <= CNT_ZERO;
            drop_cnt_q <= CNT_ZERO;
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            deq_pc_q   <= deq_pc_d;
            os_cnt_q   <= os_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    ifu_fetch_sync_fifo #(
        .DEPTH (FQ_DEPTH),
        .W     (DW)
    ) u_iq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (redirect_vld_i),
        .wr_en_i   (q_wr_s),
        .wr_data_i (rsp_ir_i),
        .rd_en_i   (q_rd_s),
        .rd_data_o (q_head_s),
        .count_o   (q_cnt_s)
    );

    ifu_fetch_chk #(
        .CW (CW)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .rsp_vld_i  (rsp_vld_i),
        .os_cnt_i   (os_cnt_q),
        .drop_cnt_i (drop_cnt_q)
    );

    assign req_vld_o  = req_vld_s;
    assign req_pc_o   = fetch_pc_q;
    assign inst_vld_o = inst_vld_s;
    assign inst_ir_o  = q_head_s;
    assign inst_pc_o  = deq_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch
// Randomised bench for ifu_fetch. A bus responder model answers each accepted
// request in order after 1..lat_max cycles with a word derived from its
// address. The expected decoder stream is the sequence of requests issued on
// the current path (since the last redirect), each paired with its word.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

    localparam int MAX_OS   = 2;
    localparam int FQ_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] req_pc;
    logic        rsp_vld;
    logic [31:0] rsp_ir;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        inst_vld;
    logic        inst_rdy;
    logic [31:0] inst_ir;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    ifu_fetch #(
        .AW       (32),
        .DW       (32),
        .RST_PC   (32'h0000_0000),
        .FQ_DEPTH (FQ_DEPTH),
        .MAX_OS   (MAX_OS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_vld_o      (req_vld),
        .req_rdy_i      (req_rdy),
        .req_pc_o       (req_pc),
        .rsp_vld_i      (rsp_vld),
        .rsp_ir_i       (rsp_ir),
        .redirect_vld_i (redirect_vld),
        .redirect_pc_i  (redirect_pc),
        .inst_vld_o     (inst_vld),
        .inst_rdy_i     (inst_rdy),
        .inst_ir_o      (inst_ir),
        .inst_pc_o      (inst_pc)
    );

    typedef struct { logic [31:0] pc; int due; bit live; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] ir; } exp_t;

    pend_t       pend_q[$];
    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          started = 1'b0;
    logic [31:0] model_pc = 32'h0000_0000;
    logic [31:0] last_pc = 32'h0000_0000;
    int          delivered = 0;
    int          live_issued = 0;
    bit          seen_wrap = 1'b0;

    int          p_req_rdy = 100;
    int          p_inst_rdy = 100;
    int          p_redir = 0;
    int          lat_max = 1;
    bit          force_redir = 1'b0;
    logic [31:0] force_pc = 32'h0000_0000;

    function automatic logic [31:0] ir_of(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver: fresh inputs just after every rising edge
    initial begin
        req_rdy = 1'b0; inst_rdy = 1'b0; rsp_vld = 1'b0; rsp_ir = 32'h0;
        redirect_vld = 1'b0; redirect_pc = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            req_rdy  = ($urandom_range(99) < p_req_rdy);
            inst_rdy = ($urandom_range(99) < p_inst_rdy);
            if (force_redir) begin
                redirect_vld = 1'b1;
                redirect_pc  = force_pc;
                force_redir  = 1'b0;
            end else if ($urandom_range(999) < p_redir) begin
                redirect_vld = 1'b1;
                redirect_pc  = $urandom & 32'h0000_0FFF;
            end else begin
                redirect_vld = 1'b0;
                redirect_pc  = $urandom;
            end
            if (rst_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                rsp_vld = 1'b1;
                rsp_ir  = ir_of(pend_q[0].pc);
            end else begin
                rsp_vld = 1'b0;
                rsp_ir  = $urandom;
            end
        end
    end

    // Reference model: request stream, responder bookkeeping, scoreboard pushes
    initial begin
        pend_t r;
        int    lat;
        forever begin
            @(negedge clk);
            #2;
            if (!started) continue;
            if (rsp_vld) begin
                r = pend_q.pop_front();
                if (r.live && !redirect_vld) exp_q.push_back('{pc: r.pc, ir: ir_of(r.pc)});
            end
            if (req_vld) check("req_pc", req_pc, model_pc);
            if (req_vld && req_rdy) begin
                lat = $urandom_range(lat_max, 1);
                pend_q.push_back('{pc: model_pc, due: cyc + lat, live: !redirect_vld});
                if (!redirect_vld) live_issued++;
                model_pc = model_pc + 32'd4;
            end
            if (redirect_vld) begin
                model_pc = redirect_pc & ~32'd3;
                exp_q.delete();
                foreach (pend_q[i]) pend_q[i].live = 1'b0;
            end
            check("outstanding_le_max", 32'(pend_q.size() <= MAX_OS), 32'd1);
            check("queue_le_depth", 32'(exp_q.size() <= FQ_DEPTH), 32'd1);
        end
    end

    // Monitor: decoder-side output against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!started) continue;
            check("inst_vld", 32'(inst_vld), 32'(exp_q.size() != 0));
            if (inst_vld && inst_rdy && !redirect_vld && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e.pc);
                check("inst_ir", inst_ir, e.ir);
                if (e.pc == 32'h0000_0000 && last_pc == 32'hFFFF_FFFC) seen_wrap = 1'b1;
                last_pc = e.pc;
                delivered++;
            end
        end
    end

    // Sequencer
    initial begin
        int d0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_req_vld", 32'(req_vld), 32'd0);
        check("rst_req_pc", req_pc, 32'h0000_0000);
        check("rst_inst_vld", 32'(inst_vld), 32'd0);
        check("rst_inst_ir", inst_ir, 32'h0000_0000);
        check("rst_inst_pc", inst_pc, 32'h0000_0000);
        @(negedge clk);
        rst_n   = 1'b1;
        started = 1'b1;
        #1;
        check("run_clear_after_release", 32'(req_vld), 32'd0);
        @(negedge clk);
        #1;
        check("run_set_first_edge", 32'(req_vld), 32'd1);

        // Straight-line streaming from reset
        repeat (30) @(posedge clk);
        check("stream_progress", 32'(delivered >= 12), 32'd1);

        // Decoder stalled: exactly FQ_DEPTH live requests, then issue stops
        p_inst_rdy  = 0;
        force_pc    = 32'h0000_0040;
        force_redir = 1'b1;
        live_issued = 0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        #3;
        check("stall_live_issued", 32'(live_issued), 32'(FQ_DEPTH));
        check("stall_req_vld", 32'(req_vld), 32'd0);
        check("stall_queue_full", 32'(exp_q.size()), 32'(FQ_DEPTH));
        check("stall_next_pc", req_pc, 32'h0000_0048);
        p_inst_rdy = 100;
        repeat (10) @(posedge clk);
        check("resume_progress", 32'(last_pc >= 32'h0000_004C), 32'd1);

        // Unaligned redirect near the top of the address space: PC wraps
        force_pc    = 32'hFFFF_FFFB;
        force_redir = 1'b1;
        repeat (20) @(posedge clk);
        check("pc_wrap_seen", 32'(seen_wrap), 32'd1);

        // Random backpressure, 1..3 cycle latency, frequent redirects
        d0         = delivered;
        p_req_rdy  = 70;
        p_inst_rdy = 70;
        p_redir    = 40;
        lat_max    = 3;
        repeat (1500) @(posedge clk);
        p_redir = 0;
        repeat (20) @(posedge clk);
        check("random_progress", 32'(delivered - d0 >= 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
